// File: rtl/sys_debug_monitor.sv
// sys_debug_monitor
//   Drives a debug LED bank from one of NUM_CH channel words. There are three
//   display modes: live (a selected channel), snapshot (a frozen copy of all
//   channels) and auto-scan (each channel in turn). A free-running heartbeat
//   output is also generated.
//
// Ports
//   clk            : single clock; all state changes on its rising edge
//   SYS_reset      : asynchronous active-high reset
//   ch_data        : channel k at bits [k*DATA_W +: DATA_W]
//   SYS_output_sel : manual channel select (live / snapshot)
//   mode           : 00 live, 01 snapshot, 10 auto-scan, 11 live
//   snap_req       : capture request; captures on its rising edge only
//   SYS_leds       : displayed word, registered
//   cur_ch         : index of the channel shown on SYS_leds, registered
//   snap_valid     : set once at least one snapshot has been captured
//   CLK_led        : heartbeat that toggles every CLK_DIV cycles
//
// Auto-scan states
//   state   | meaning
//   IDLE    | not in auto-scan; index and dwell counter held at 0
//   DWELL   | showing channel scan_idx; scan_cnt counts the dwell cycles
//   ADVANCE | first cycle on a new index; counts like DWELL
module sys_debug_monitor #(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 32,
  parameter int LED_W    = 27,
  parameter int SCAN_CYC = 50000000,
  parameter int CLK_DIV  = 25000000,
  localparam int SEL_W   = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     SYS_reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         SYS_output_sel,
  input  logic [1:0]               mode,
  input  logic                     snap_req,
  output logic [LED_W-1:0]         SYS_leds,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     snap_valid,
  output logic                     CLK_led
);

  localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int HB_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DWELL   = 2'd1,
    ADVANCE = 2'd2
  } scan_state_t;

  logic [DATA_W-1:0] ch_arr [NUM_CH];
  logic [DATA_W-1:0] shadow [NUM_CH];

  scan_state_t       state;
  logic [SEL_W-1:0]  scan_idx;
  logic [SEL_W-1:0]  idx_inc;
  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_at_tc;
  logic [HB_W-1:0]   hb_cnt;
  logic              snap_q;
  logic              capture;
  logic              sel_ok;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
  end

  // Truncates when DATA_W >= LED_W, zero-extends otherwise.
  function automatic logic [LED_W-1:0] to_led(input logic [DATA_W-1:0] d);
    return LED_W'(d);
  endfunction

  assign capture    = snap_req & ~snap_q;
  // Selects past the last channel (non-power-of-2 NUM_CH) show a blank word.
  assign sel_ok     = (int'(SYS_output_sel) < NUM_CH);
  assign scan_at_tc = (scan_cnt == SCAN_W'(SCAN_CYC - 1));
  assign idx_inc    = (scan_idx == SEL_W'(NUM_CH - 1)) ? '0 : scan_idx + SEL_W'(1);

  // The shadow bank is left unreset: nothing reads it until snap_valid is set.
  always_ff @(posedge clk) begin
    if (capture) shadow <= ch_arr;
  end

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state      <= IDLE;
      scan_idx   <= '0;
      scan_cnt   <= '0;
      snap_q     <= 1'b0;
      snap_valid <= 1'b0;
      cur_ch     <= '0;
      SYS_leds   <= '0;
    end else begin
      snap_q <= snap_req;
      if (capture) snap_valid <= 1'b1;

      if (mode == 2'b10) begin
        case (state)
          IDLE: begin
            state    <= DWELL;
            scan_idx <= '0;
            scan_cnt <= '0;
            cur_ch   <= '0;
            SYS_leds <= to_led(ch_arr[0]);
          end
          default: begin
            // The step to the next index happens on the terminal-count edge,
            // so each index is displayed for exactly SCAN_CYC cycles.
            if (scan_at_tc) begin
              state    <= ADVANCE;
              scan_idx <= idx_inc;
              scan_cnt <= '0;
              cur_ch   <= idx_inc;
              SYS_leds <= to_led(ch_arr[idx_inc]);
            end else begin
              state    <= DWELL;
              scan_cnt <= scan_cnt + SCAN_W'(1);
              cur_ch   <= scan_idx;
              SYS_leds <= to_led(ch_arr[scan_idx]);
            end
          end
        endcase
      end else begin
        state    <= IDLE;
        scan_idx <= '0;
        scan_cnt <= '0;
        cur_ch   <= SYS_output_sel;
        if (!sel_ok)
          SYS_leds <= '0;
        else if (mode == 2'b01)
          // Reads the registered snap_valid and shadow, so a capture landing
          // on this edge shows up one cycle later.
          SYS_leds <= snap_valid ? to_led(shadow[SYS_output_sel]) : '0;
        else
          SYS_leds <= to_led(ch_arr[SYS_output_sel]);
      end
    end
  end

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      hb_cnt  <= '0;
      CLK_led <= 1'b0;
    end else if (hb_cnt == HB_W'(CLK_DIV - 1)) begin
      hb_cnt  <= '0;
      CLK_led <= ~CLK_led;
    end else begin
      hb_cnt  <= hb_cnt + HB_W'(1);
    end
  end

endmodule

// File: tb/tb_sys_debug_monitor.sv
module tb_sys_debug_monitor;

  logic          clk = 1'b0;
  logic          SYS_reset;
  logic [255:0]  ch_data;
  logic [2:0]    sel;
  logic [1:0]    mode;
  logic          snap_req;
  logic [26:0]   leds;
  logic [2:0]    cur_ch;
  logic          snap_valid;
  logic          clk_led;

  logic [191:0]  ch_data6;
  logic [2:0]    sel6;
  logic [1:0]    mode6;
  logic          snap_req6;
  logic [26:0]   leds6;
  logic [2:0]    cur_ch6;
  logic          snap_valid6;
  logic          clk_led6;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sys_debug_monitor #(
    .NUM_CH(8), .DATA_W(32), .LED_W(27), .SCAN_CYC(4), .CLK_DIV(2)
  ) dut (
    .clk(clk), .SYS_reset(SYS_reset), .ch_data(ch_data),
    .SYS_output_sel(sel), .mode(mode), .snap_req(snap_req),
    .SYS_leds(leds), .cur_ch(cur_ch), .snap_valid(snap_valid), .CLK_led(clk_led)
  );

  sys_debug_monitor #(
    .NUM_CH(6), .DATA_W(32), .LED_W(27), .SCAN_CYC(4), .CLK_DIV(2)
  ) dut6 (
    .clk(clk), .SYS_reset(SYS_reset), .ch_data(ch_data6),
    .SYS_output_sel(sel6), .mode(mode6), .snap_req(snap_req6),
    .SYS_leds(leds6), .cur_ch(cur_ch6), .snap_valid(snap_valid6), .CLK_led(clk_led6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    ch_data[k*32 +: 32] = v;
  endtask

  task automatic async_reset_check(input string tag);
    #1;
    SYS_reset = 1'b1;
    #1;
    chk({tag, "_leds"},  32'(leds), 32'h0);
    chk({tag, "_cur"},   32'(cur_ch), 32'h0);
    chk({tag, "_snapv"}, 32'(snap_valid), 32'h0);
    chk({tag, "_hb"},    32'(clk_led), 32'h0);
    #2;
    SYS_reset = 1'b0;
  endtask

  initial begin
    SYS_reset = 1'b1;
    ch_data   = '0;
    sel       = '0;
    mode      = 2'b00;
    snap_req  = 1'b0;
    ch_data6  = '0;
    sel6      = '0;
    mode6     = 2'b00;
    snap_req6 = 1'b0;

    #2;
    chk("rst_leds",  32'(leds), 32'h0);
    chk("rst_cur",   32'(cur_ch), 32'h0);
    chk("rst_snapv", 32'(snap_valid), 32'h0);
    chk("rst_hb",    32'(clk_led), 32'h0);
    chk("rst_leds6", 32'(leds6), 32'h0);
    tick;
    tick;
    SYS_reset = 1'b0;

    // Heartbeat: toggles on every second edge regardless of mode.
    for (int n = 1; n <= 8; n++) begin
      mode = 2'(n);
      tick;
      chk("hb", 32'(clk_led), 32'((n / 2) % 2));
    end

    // Snapshot mode before any capture shows a blank word.
    for (int k = 0; k < 8; k++) set_ch(k, 32'h0555_0000 + 32'(k));
    mode = 2'b01;
    sel  = 3'd2;
    tick;
    chk("nosnap_leds",  32'(leds), 32'h0);
    chk("nosnap_snapv", 32'(snap_valid), 32'h0);

    // Live mode.
    set_ch(3, 32'hDEAD_BEEF);
    sel  = 3'd3;
    mode = 2'b00;
    chk("live_latency", 32'(leds), 32'h0);
    tick;
    chk("live_leds", 32'(leds), 32'h6AD_BEEF);
    chk("live_cur",  32'(cur_ch), 32'd3);
    set_ch(1, 32'h0ABC_DEF1);
    sel = 3'd1;
    tick;
    chk("live1_leds", 32'(leds), 32'h2BC_DEF1);
    chk("live1_cur",  32'(cur_ch), 32'd1);
    mode = 2'b11;
    sel  = 3'd3;
    tick;
    chk("live11_leds", 32'(leds), 32'h6AD_BEEF);
    chk("live11_cur",  32'(cur_ch), 32'd3);

    // Snapshot capture from live mode.
    set_ch(5, 32'h1234_5678);
    snap_req = 1'b1;
    tick;
    snap_req = 1'b0;
    chk("snap_valid", 32'(snap_valid), 32'h1);
    set_ch(5, 32'h0);
    mode = 2'b01;
    sel  = 3'd5;
    tick;
    chk("snap_leds", 32'(leds), 32'h234_5678);
    chk("snap_cur",  32'(cur_ch), 32'd5);

    // snap_req held for three cycles captures only on the first.
    set_ch(5, 32'hAAAA_0001);
    snap_req = 1'b1;
    tick;
    chk("snap_coincide_old", 32'(leds), 32'h234_5678);
    set_ch(5, 32'hBBBB_0002);
    tick;
    chk("snap_new", 32'(leds), 32'h2AA_0001);
    set_ch(5, 32'hCCCC_0003);
    tick;
    chk("snap_held2", 32'(leds), 32'h2AA_0001);
    snap_req = 1'b0;
    tick;
    chk("snap_held3", 32'(leds), 32'h2AA_0001);

    // Mode switches leave shadow contents alone.
    mode = 2'b00;
    tick;
    mode = 2'b01;
    tick;
    chk("snap_keep_leds",  32'(leds), 32'h2AA_0001);
    chk("snap_keep_snapv", 32'(snap_valid), 32'h1);

    // Auto-scan: index steps every 4 cycles and wraps 7 -> 0.
    for (int k = 0; k < 8; k++) set_ch(k, 32'(k + 1));
    sel  = 3'd6;
    mode = 2'b10;
    for (int j = 0; j < 54; j++) begin
      tick;
      chk("scan_cur",  32'(cur_ch), 32'((j / 4) % 8));
      chk("scan_leds", 32'(leds), 32'((j / 4) % 8 + 1));
    end
    chk("pre_reset_snapv", 32'(snap_valid), 32'h1);

    // Reset mid-scan at index 5, then again 130 ns later.
    async_reset_check("rst1");
    for (int j = 0; j < 13; j++) begin
      tick;
      chk("rst1_scan_cur",  32'(cur_ch), 32'(j / 4));
      chk("rst1_scan_leds", 32'(leds), 32'(j / 4 + 1));
      chk("rst1_hb",        32'(clk_led), 32'(((j + 1) / 2) % 2));
      chk("rst1_snapv",     32'(snap_valid), 32'h0);
    end
    async_reset_check("rst2");
    for (int j = 0; j < 8; j++) begin
      tick;
      chk("rst2_scan_cur", 32'(cur_ch), 32'(j / 4));
      chk("rst2_hb",       32'(clk_led), 32'(((j + 1) / 2) % 2));
    end

    // Six-channel instance: out-of-range selects show a blank word.
    ch_data6 = '1;
    sel6 = 3'd7;
    tick;
    chk("nch6_sel7_leds", 32'(leds6), 32'h0);
    chk("nch6_sel7_cur",  32'(cur_ch6), 32'd7);
    sel6 = 3'd6;
    tick;
    chk("nch6_sel6_leds", 32'(leds6), 32'h0);
    chk("nch6_sel6_cur",  32'(cur_ch6), 32'd6);
    sel6 = 3'd5;
    tick;
    chk("nch6_sel5_leds", 32'(leds6), 32'h7FF_FFFF);
    chk("nch6_sel5_cur",  32'(cur_ch6), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
